// File: rtl/regbank_pkg.sv
// Shared types and default widths for the register-bank write-back arbiter.
package regbank_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned WAIT_CNT_W     = 4;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_B_TURN = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// In-flight destination tracker: one busy bit per register, r0 never busy.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] q_idx,
  output logic                  q_busy,
  input  logic [ADDR_WIDTH-1:0] rs,
  output logic                  rs_busy,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic                  rt_busy
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear applied before set so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign q_busy  = busy_q[q_idx];
  assign rs_busy = busy_q[rs];
  assign rt_busy = busy_q[rt];

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Two-requester write-back arbiter for the register bank's single write port,
// with A-priority plus aging for B, and a RAW/WAW scoreboard for decode.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  rf_en,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_t              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    rf_en_q, rf_en_d;
  logic [ADDR_WIDTH-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0]   rf_data_q, rf_data_d;

  logic a_gnt;
  logic b_gnt;
  logic issue_busy;
  logic issue_set;

  // Grant selection and aging: B is forced after MAX_WAIT straight conflict losses.
  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == ARB_NORMAL) begin
      if (a_valid) begin
        a_gnt = 1'b1;
        if (b_valid) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = ARB_B_TURN;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
      end else if (b_valid) begin
        b_gnt = 1'b1;
      end
    end else begin
      if (b_valid) begin
        b_gnt = 1'b1;
      end else if (a_valid) begin
        a_gnt = 1'b1;
      end
    end
    if (b_gnt) begin
      state_d    = ARB_NORMAL;
      wait_cnt_d = '0;
    end
  end

  // Write-port staging; r0 writes are consumed without enabling the bank.
  always_comb begin
    rf_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (a_gnt) begin
      rf_en_d   = (a_rd != '0);
      rf_rd_d   = a_rd;
      rf_data_d = a_data;
    end else if (b_gnt) begin
      rf_en_d   = (b_rd != '0);
      rf_rd_d   = b_rd;
      rf_data_d = b_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_NORMAL;
      wait_cnt_q <= '0;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_en_q    <= rf_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign a_ready     = rst & a_gnt;
  assign b_ready     = rst & b_gnt;
  assign issue_ready = rst & ((issue_rd == '0) | ~issue_busy);
  assign issue_set   = issue_valid & issue_ready & (issue_rd != '0);

  regbank_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_set),
    .set_idx (issue_rd),
    .clr_en  (rf_en_q),
    .clr_idx (rf_rd_q),
    .q_idx   (issue_rd),
    .q_busy  (issue_busy),
    .rs      (rs),
    .rs_busy (rs_busy),
    .rt      (rt),
    .rt_busy (rt_busy)
  );

  assign rf_en   = rf_en_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

endmodule
